// File: rtl/life_engine_if.sv
// Host-side bundle of the life engine: commands, rules, cell write port,
// display read port and status.
interface life_engine_if #(
  parameter int unsigned LOG_W = 6,
  parameter int unsigned LOG_H = 5
);
  logic                   step;
  logic                   init;
  logic [8:0]             rule_birth;
  logic [8:0]             rule_survive;
  logic                   wrap_en;
  logic                   wr_en;
  logic [LOG_W-1:0]       wr_x;
  logic [LOG_H-1:0]       wr_y;
  logic                   wr_data;
  logic [LOG_W-1:0]       rd_x;
  logic [LOG_H-1:0]       rd_y;
  logic                   rd_cell;
  logic                   busy;
  logic                   done;
  logic [15:0]            generation;
  logic [LOG_W+LOG_H:0]   population;

  modport master (
    output step, init, rule_birth, rule_survive, wrap_en,
    output wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    input  rd_cell, busy, done, generation, population
  );

  modport slave (
    input  step, init, rule_birth, rule_survive, wrap_en,
    input  wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    output rd_cell, busy, done, generation, population
  );
endinterface

// File: rtl/life_engine.sv
// Game-of-Life generation engine: two ping-pong cell banks, LFSR random fill,
// programmable birth/survive rules, toroidal or dead edges.
module life_engine #(
  parameter int unsigned LOG_W = 6,
  parameter int unsigned LOG_H = 5,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input logic          clk,
  input logic          rst_n,
  life_engine_if.slave bus
);
  localparam int unsigned AW    = LOG_W + LOG_H;
  localparam int unsigned BOARD = 1 << AW;
  localparam int unsigned PW    = AW + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StInit   = 2'd1;
  localparam logic [1:0] StUpdate = 2'd2;
  localparam logic [1:0] StSwap   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          pending_q, pending_d;
  logic          bank_sel_q, bank_sel_d;
  logic          done_q, done_d;
  logic [15:0]   gen_q, gen_d;
  logic [PW-1:0] pop_q, pop_d;
  logic [PW-1:0] shadow_q, shadow_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    phase_q, phase_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    birth_q, birth_d;
  logic [8:0]    survive_q, survive_d;
  logic          wrap_q, wrap_d;

  logic [BOARD-1:0] mem_q [2];
  logic             mem_we;
  logic             mem_bank;
  logic [AW-1:0]    mem_addr;
  logic             mem_wdata;

  logic [BOARD-1:0] cur_bank;
  logic [LOG_W-1:0] cx;
  logic [LOG_H-1:0] cy;
  logic             dx_m, dx_p, dy_m, dy_p;
  logic [LOG_W:0]   nx_ext;
  logic [LOG_H:0]   ny_ext;
  logic             nb_bit;
  logic             next_cell;

  assign cur_bank = mem_q[bank_sel_q];
  assign cx       = idx_q[LOG_W-1:0];
  assign cy       = idx_q[AW-1:LOG_W];

  // Neighbour visit order for phases 0..7: row above, same row, row below.
  always_comb begin
    dx_m = 1'b0;
    dx_p = 1'b0;
    dy_m = 1'b0;
    dy_p = 1'b0;
    case (phase_q)
      4'd0:    begin dx_m = 1'b1; dy_m = 1'b1; end
      4'd1:    dy_m = 1'b1;
      4'd2:    begin dx_p = 1'b1; dy_m = 1'b1; end
      4'd3:    dx_m = 1'b1;
      4'd4:    dx_p = 1'b1;
      4'd5:    begin dx_m = 1'b1; dy_p = 1'b1; end
      4'd6:    dy_p = 1'b1;
      4'd7:    begin dx_p = 1'b1; dy_p = 1'b1; end
      default: ;
    endcase
  end

  // The extra MSB flags a step off the board; the low bits are the wrapped coordinate.
  assign nx_ext = {1'b0, cx} + {{LOG_W{1'b0}}, dx_p} - {{LOG_W{1'b0}}, dx_m};
  assign ny_ext = {1'b0, cy} + {{LOG_H{1'b0}}, dy_p} - {{LOG_H{1'b0}}, dy_m};
  assign nb_bit = cur_bank[{ny_ext[LOG_H-1:0], nx_ext[LOG_W-1:0]}] &
                  (wrap_q | ~(nx_ext[LOG_W] | ny_ext[LOG_H]));
  assign next_cell = cur_bank[idx_q] ? survive_q[cnt_q] : birth_q[cnt_q];

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    bank_sel_d = bank_sel_q;
    done_d     = 1'b0;
    gen_d      = gen_q;
    pop_d      = pop_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    birth_d    = birth_q;
    survive_d  = survive_q;
    wrap_d     = wrap_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    mem_we     = 1'b0;
    mem_bank   = bank_sel_q;
    mem_addr   = idx_q;
    mem_wdata  = 1'b0;

    case (state_q)
      StIdle: begin
        if (pending_q || bus.init || bus.step) begin
          state_d   = (pending_q || bus.init) ? StInit : StUpdate;
          idx_d     = '0;
          phase_d   = '0;
          cnt_d     = '0;
          shadow_d  = '0;
          birth_d   = bus.rule_birth;
          survive_d = bus.rule_survive;
          wrap_d    = bus.wrap_en;
        end else if (bus.wr_en) begin
          mem_we    = 1'b1;
          mem_addr  = {bus.wr_y, bus.wr_x};
          mem_wdata = bus.wr_data;
        end
      end
      StInit: begin
        mem_we    = 1'b1;
        mem_wdata = lfsr_q[0];
        shadow_d  = shadow_q + {{AW{1'b0}}, lfsr_q[0]};
        idx_d     = idx_q + 1'b1;
        if (&idx_q) begin
          state_d   = StIdle;
          pending_d = 1'b0;
          pop_d     = shadow_d;
          gen_d     = '0;
          done_d    = 1'b1;
        end
      end
      StUpdate: begin
        if (phase_q != 4'd8) begin
          cnt_d   = cnt_q + {3'b000, nb_bit};
          phase_d = phase_q + 4'd1;
        end else begin
          // Results go to the hidden bank so the displayed image stays frozen.
          mem_we    = 1'b1;
          mem_bank  = ~bank_sel_q;
          mem_wdata = next_cell;
          shadow_d  = shadow_q + {{AW{1'b0}}, next_cell};
          cnt_d     = '0;
          phase_d   = '0;
          idx_d     = idx_q + 1'b1;
          if (&idx_q) state_d = StSwap;
        end
      end
      StSwap: begin
        bank_sel_d = ~bank_sel_q;
        pop_d      = shadow_q;
        gen_d      = gen_q + 16'd1;
        state_d    = StIdle;
        done_d     = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= 1'b1;
      bank_sel_q <= 1'b0;
      done_q     <= 1'b0;
      gen_q      <= '0;
      pop_q      <= '0;
      shadow_q   <= '0;
      lfsr_q     <= SEED;
      idx_q      <= '0;
      phase_q    <= '0;
      cnt_q      <= '0;
      birth_q    <= '0;
      survive_q  <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      bank_sel_q <= bank_sel_d;
      done_q     <= done_d;
      gen_q      <= gen_d;
      pop_q      <= pop_d;
      shadow_q   <= shadow_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      birth_q    <= birth_d;
      survive_q  <= survive_d;
      wrap_q     <= wrap_d;
    end
  end

  // Cell storage carries no reset; a fresh INIT always rewrites it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_bank][mem_addr] <= mem_wdata;
  end

  assign bus.rd_cell    = cur_bank[{bus.rd_y, bus.rd_x}];
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.generation = gen_q;
  assign bus.population = pop_q;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine on an 8x8 board: whole-board reference model, per-cycle
// compare of status and display, directed patterns and randomized rules/writes.
module tb_life_engine;
  localparam int unsigned LOG_W = 3;
  localparam int unsigned LOG_H = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int B  = 64;
  localparam int PW = 7;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_00E0_8040;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  life_engine_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();

  life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H), .SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: board image, known-cell mask, status, op countdown.
  logic [B-1:0]  m_board, m_next, m_known;
  logic          m_busy, m_done, m_pend, m_is_init;
  logic [15:0]   m_gen, m_lfsr;
  logic [PW-1:0] m_pop;
  int            m_rem;

  logic [5:0] rd_idx     = '0;
  logic [5:0] rd_fix_idx = '0;
  logic       rd_fix_en  = 1'b0;

  function automatic logic [B-1:0] life_gen(input logic [B-1:0] b, input logic [8:0] bi,
                                            input logic [8:0] su, input logic wr);
    logic [B-1:0] r;
    r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = x + dx;
            ny = y + dy;
            if (dx == 0 && dy == 0) continue;
            if (wr) begin
              nx = (nx + W) % W;
              ny = (ny + H) % H;
            end else if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
              continue;
            end
            n += int'(b[ny*W+nx]);
          end
        end
        r[y*W+x] = b[y*W+x] ? su[n] : bi[n];
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_pend    <= 1'b1;
      m_is_init <= 1'b0;
      m_gen     <= '0;
      m_pop     <= '0;
      m_rem     <= 0;
      m_known   <= '0;
      m_lfsr    <= SEED;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_done <= 1'b0;
      if (!m_busy) begin
        if (m_pend || bus.init) begin
          m_busy    <= 1'b1;
          m_is_init <= 1'b1;
          m_rem     <= B;
        end else if (bus.step) begin
          m_busy    <= 1'b1;
          m_is_init <= 1'b0;
          m_rem     <= 9*B + 1;
          m_next    <= life_gen(m_board, bus.rule_birth, bus.rule_survive, bus.wrap_en);
        end else if (bus.wr_en) begin
          m_board[{bus.wr_y, bus.wr_x}] <= bus.wr_data;
          m_known[{bus.wr_y, bus.wr_x}] <= 1'b1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_is_init) begin
          m_board[B-m_rem] <= m_lfsr[0];
          m_known[B-m_rem] <= 1'b1;
        end
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (m_is_init) begin
            m_pend <= 1'b0;
            m_gen  <= '0;
            m_pop  <= PW'($countones(m_board[B-2:0]) + int'(m_lfsr[0]));
          end else begin
            m_board <= m_next;
            m_pop   <= PW'($countones(m_next));
            m_gen   <= m_gen + 16'd1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr_cell(input int x, input int y, input logic d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_x    = 3'(x);
    bus.wr_y    = 3'(y);
    bus.wr_data = d;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic clear_board();
    for (int i = 0; i < B; i++) wr_cell(i % W, i / W, 1'b0);
  endtask

  task automatic peek(input int idx, input logic exp, input string name);
    rd_fix_idx = 6'(idx);
    rd_fix_en  = 1'b1;
    @(negedge clk);
    #1 check(name, bus.rd_cell, exp);
    rd_fix_en = 1'b0;
  endtask

  task automatic wait_done(inout int edges);
    while (!bus.done && edges < 9*B + 20) begin
      @(posedge clk);
      #1 edges++;
    end
    if (!bus.done) check("op_timeout", bus.done, 1);
  endtask

  task automatic run_op(input logic s, input logic i, output int edges);
    @(negedge clk);
    bus.step = s;
    bus.init = i;
    @(posedge clk);
    #1;
    bus.step = 1'b0;
    bus.init = 1'b0;
    edges = 1;
    check("busy_on_accept", bus.busy, 1);
    wait_done(edges);
  endtask

  initial begin
    int e;
    logic [15:0] g0;
    bus.step = 1'b0; bus.init = 1'b0; bus.wr_en = 1'b0;
    bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = 1'b0;
    bus.rd_x = '0; bus.rd_y = '0;
    bus.rule_birth = 9'h008; bus.rule_survive = 9'h00C; bus.wrap_en = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          check("busy", bus.busy, m_busy);
          check("done", bus.done, m_done);
          check("generation", bus.generation, m_gen);
          check("population", bus.population, m_pop);
          if (m_known[rd_idx]) check("rd_cell", bus.rd_cell, m_board[rd_idx]);
        end
        rd_idx   = rd_fix_en ? rd_fix_idx : 6'($urandom);
        bus.rd_x = rd_idx[2:0];
        bus.rd_y = rd_idx[5:3];
      end
    join_none

    // Power-on reset and the automatic random fill.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_gen", bus.generation, 0);
    check("rst_pop", bus.population, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("busy_2nd_cycle", bus.busy, 1);
    e = 1;
    wait_done(e);
    check("init_done_cycle", e + 1, 66);
    check("init_gen", bus.generation, 0);

    // Blinker, Conway rules.
    clear_board();
    wr_cell(2, 3, 1'b1); wr_cell(3, 3, 1'b1); wr_cell(4, 3, 1'b1);
    check("blinker_model_h", m_board, BLINK_H);
    run_op(1'b1, 1'b0, e);
    check("step_latency", e, 9*B + 2);
    check("blinker_model_v", m_board, BLINK_V);
    check("blinker_pop", bus.population, 3);
    check("blinker_gen1", bus.generation, 1);
    peek(19, 1'b1, "blinker_v_top");
    peek(35, 1'b1, "blinker_v_bot");
    peek(26, 1'b0, "blinker_v_left");
    run_op(1'b1, 1'b0, e);
    check("blinker_model_h2", m_board, BLINK_H);
    check("blinker_gen2", bus.generation, 2);
    peek(28, 1'b1, "blinker_h_right");

    // Glider on a torus returns home after 32 generations.
    clear_board();
    wr_cell(6, 0, 1'b1); wr_cell(7, 1, 1'b1);
    wr_cell(5, 2, 1'b1); wr_cell(6, 2, 1'b1); wr_cell(7, 2, 1'b1);
    check("glider_model", m_board, GLIDER);
    for (int i = 0; i < 32; i++) begin
      run_op(1'b1, 1'b0, e);
      check("glider_pop", bus.population, 5);
    end
    check("glider_return", m_board, GLIDER);
    check("glider_gen", bus.generation, 34);
    peek(6, 1'b1, "glider_cell6");

    // Same glider against dead edges.
    clear_board();
    wr_cell(6, 0, 1'b1); wr_cell(7, 1, 1'b1);
    wr_cell(5, 2, 1'b1); wr_cell(6, 2, 1'b1); wr_cell(7, 2, 1'b1);
    bus.wrap_en = 1'b0;
    for (int i = 0; i < 12; i++) run_op(1'b1, 1'b0, e);

    // Inputs disturbed while busy must not affect the running generation.
    bus.wrap_en = 1'b1;
    g0 = bus.generation;
    @(negedge clk);
    bus.step = 1'b1;
    @(posedge clk);
    #1 bus.step = 1'b0;
    e = 1;
    repeat (100) begin
      @(posedge clk);
      #1 e++;
    end
    @(negedge clk);
    bus.rule_birth = 9'h1FF;
    bus.step = 1'b1; bus.init = 1'b1;
    bus.wr_en = 1'b1; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = ~m_board[0];
    repeat (2) begin
      @(posedge clk);
      #1 e++;
    end
    bus.step = 1'b0; bus.init = 1'b0; bus.wr_en = 1'b0;
    wait_done(e);
    check("busy_step_latency", e, 9*B + 2);
    check("busy_gen_once", bus.generation, g0 + 16'd1);
    bus.rule_birth = 9'h008;
    repeat (3) @(negedge clk);
    check("no_queued_op", bus.busy, 0);
    peek(0, m_board[0], "wr_ignored");

    // step and init together: init wins.
    run_op(1'b1, 1'b1, e);
    check("init_latency", e, B + 1);
    check("init_gen0", bus.generation, 0);

    // Randomized rules, edges, writes and refills.
    for (int i = 0; i < 8; i++) begin
      bus.rule_birth   = 9'($urandom);
      bus.rule_survive = 9'($urandom);
      bus.wrap_en      = 1'($urandom);
      repeat ($urandom_range(0, 4)) wr_cell($urandom_range(0, 7), $urandom_range(0, 7),
                                            1'($urandom));
      if ($urandom_range(0, 4) == 0) run_op(1'b0, 1'b1, e);
      else                           run_op(1'b1, 1'b0, e);
    end

    // Asynchronous reset in the middle of an update.
    bus.rule_birth = 9'h008; bus.rule_survive = 9'h00C; bus.wrap_en = 1'b1;
    @(negedge clk);
    bus.step = 1'b1;
    @(posedge clk);
    #1 bus.step = 1'b0;
    repeat (200) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_gen", bus.generation, 0);
    check("midrst_pop", bus.population, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("midrst_busy_again", bus.busy, 1);
    e = 1;
    wait_done(e);
    check("midrst_init_cycle", e + 1, 66);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
